// File: rtl/lbnl_afe_pkg.sv
// Shared definitions for the AFE calibration sequencer.
// Holds the sequencer state encoding, the threshold-trim width and a
// small helper for turning a programmed length into a down-counter preload.
package lbnl_afe_pkg;

  localparam int TRIM_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRIM   = 3'd1,
    SETTLE = 3'd2,
    INJECT = 3'd3,
    WAIT   = 3'd4,
    GAP    = 3'd5,
    DONE   = 3'd6
  } state_t;

  // A zero pulse length still yields a one-cycle pulse, so the preload
  // for the down-counter never underflows.
  function automatic logic [7:0] len_m1(input logic [7:0] len);
    return (len == 8'd0) ? 8'd0 : len - 8'd1;
  endfunction

endpackage

// File: rtl/lbnl_afe_sync2.sv
// Two-flop synchronizer for the asynchronous discriminator output.
// Both flops reset to 1 because outdis is active-low: 1 means "no hit".
module lbnl_afe_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lbnl_afe_cal_seq.sv
// AFE calibration burst sequencer.
// Applies threshold trims, waits for them to settle, then fires n_inj
// injection strobes on S0 or S1, counting one hit per injection.
// Optional macro LBNL_AFE_TOT_EN adds time-over-threshold accumulation
// into tot_sum; without it tot_sum is tied to zero.
module lbnl_afe_cal_seq
  import lbnl_afe_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int SETTLE_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    n_inj,
  input  logic [7:0]          pulse_len,
  input  logic [7:0]          window,
  input  logic [7:0]          gap,
  input  logic [SETTLE_W-1:0] settle,
  input  logic [TRIM_W-1:0]   dth1_cfg,
  input  logic [TRIM_W-1:0]   dth2_cfg,
  input  logic                inj_sel,
  input  logic                outdis,
  output logic                S0,
  output logic                S1,
  output logic [TRIM_W-1:0]   DTH1,
  output logic [TRIM_W-1:0]   DTH2,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [15:0]         tot_sum
);

  localparam int TMR_W = (SETTLE_W > 8) ? SETTLE_W : 8;

  state_t              state, state_nx;
  logic [TMR_W-1:0]    timer, timer_nx;
  logic [CNT_W-1:0]    inj_left, left_nx;
  logic [7:0]          pulse_q, window_q, gap_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                sel_q;
  logic                accept;
  logic                new_inj;
  logic                to_wait_chk, to_gap_chk, to_inj_chk;
  logic                outdis_sync;
  logic                hit, hit_en, hit_seen;

  assign accept = (state == IDLE) && start;
  assign hit    = ~outdis_sync;
  assign hit_en = (state == INJECT) || (state == WAIT);

  assign S0   = (state == INJECT) && !sel_q;
  assign S1   = (state == INJECT) &&  sel_q;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  lbnl_afe_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (outdis),
    .q     (outdis_sync)
  );

  // Next-state logic: zero-length phases fall through to the following
  // phase in the same cycle, and abort overrides every other transition.
  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    left_nx     = inj_left;
    new_inj     = 1'b0;
    to_wait_chk = 1'b0;
    to_gap_chk  = 1'b0;
    to_inj_chk  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = TRIM;
          left_nx  = n_inj;
        end
      end
      TRIM: begin
        if (settle_q != '0) begin
          state_nx = SETTLE;
          timer_nx = TMR_W'(settle_q - SETTLE_W'(1));
        end else begin
          to_inj_chk = 1'b1;
        end
      end
      SETTLE: begin
        if (timer == '0) to_inj_chk = 1'b1;
        else             timer_nx = timer - TMR_W'(1);
      end
      INJECT: begin
        if (timer == '0) to_wait_chk = 1'b1;
        else             timer_nx = timer - TMR_W'(1);
      end
      WAIT: begin
        if (timer == '0) to_gap_chk = 1'b1;
        else             timer_nx = timer - TMR_W'(1);
      end
      GAP: begin
        if (timer == '0) to_inj_chk = 1'b1;
        else             timer_nx = timer - TMR_W'(1);
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (to_wait_chk) begin
      if (window_q != 8'd0) begin
        state_nx = WAIT;
        timer_nx = TMR_W'(window_q - 8'd1);
      end else begin
        to_gap_chk = 1'b1;
      end
    end
    if (to_gap_chk) begin
      if (gap_q != 8'd0) begin
        state_nx = GAP;
        timer_nx = TMR_W'(gap_q - 8'd1);
      end else begin
        to_inj_chk = 1'b1;
      end
    end
    if (to_inj_chk) begin
      if (inj_left != '0) begin
        state_nx = INJECT;
        timer_nx = TMR_W'(len_m1(pulse_q));
        left_nx  = inj_left - CNT_W'(1);
        new_inj  = 1'b1;
      end else begin
        state_nx = DONE;
      end
    end

    if (abort && (state != IDLE)) begin
      state_nx = IDLE;
      new_inj  = 1'b0;
    end
  end

  // Sequencer state, phase timer and remaining-injection count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      inj_left <= '0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      inj_left <= left_nx;
    end
  end

  // Capture trims and burst configuration on an accepted start only, so
  // they stay stable for the whole burst and after it completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DTH1     <= '0;
      DTH2     <= '0;
      pulse_q  <= '0;
      window_q <= '0;
      gap_q    <= '0;
      settle_q <= '0;
      sel_q    <= 1'b0;
    end else if (accept) begin
      DTH1     <= dth1_cfg;
      DTH2     <= dth2_cfg;
      pulse_q  <= pulse_len;
      window_q <= window;
      gap_q    <= gap;
      settle_q <= settle;
      sel_q    <= inj_sel;
    end
  end

  // Count at most one hit per injection; hit_seen re-arms on every new
  // injection and the counter saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      hit_seen <= 1'b0;
    end else if (accept) begin
      hit_cnt  <= '0;
      hit_seen <= 1'b0;
    end else begin
      if (hit_en && hit && !hit_seen && (hit_cnt != '1))
        hit_cnt <= hit_cnt + CNT_W'(1);
      hit_seen <= new_inj ? 1'b0 : (hit_seen | (hit_en & hit));
    end
  end

`ifdef LBNL_AFE_TOT_EN
  logic [15:0] tot_q;

  // Accumulate every enabled cycle with the discriminator firing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tot_q <= '0;
    else if (accept)
      tot_q <= '0;
    else if (hit_en && hit && (tot_q != 16'hFFFF))
      tot_q <= tot_q + 16'd1;
  end

  assign tot_sum = tot_q;
`else
  assign tot_sum = '0;
`endif

endmodule

// File: tb/tb_lbnl_afe_cal_seq.sv
// Self-checking bench for lbnl_afe_cal_seq.
// A table of burst configurations with expected results, a scoreboard
// queue popped on each done pulse, and hand-written abort/reset sequences.
module tb_lbnl_afe_cal_seq;

  localparam int CNT_W    = 8;
  localparam int SETTLE_W = 10;
`ifdef LBNL_AFE_TOT_EN
  localparam bit TOT_ON = 1'b1;
`else
  localparam bit TOT_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, abort;
  logic [CNT_W-1:0]    n_inj;
  logic [7:0]          pulse_len, window, gap;
  logic [SETTLE_W-1:0] settle;
  logic [3:0]          dth1_cfg, dth2_cfg;
  logic                inj_sel, outdis;
  logic                S0, S1, busy, done;
  logic [3:0]          DTH1, DTH2;
  logic [CNT_W-1:0]    hit_cnt;
  logic [15:0]         tot_sum;

  lbnl_afe_cal_seq #(.CNT_W(CNT_W), .SETTLE_W(SETTLE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .n_inj     (n_inj),
    .pulse_len (pulse_len),
    .window    (window),
    .gap       (gap),
    .settle    (settle),
    .dth1_cfg  (dth1_cfg),
    .dth2_cfg  (dth2_cfg),
    .inj_sel   (inj_sel),
    .outdis    (outdis),
    .S0        (S0),
    .S1        (S1),
    .DTH1      (DTH1),
    .DTH2      (DTH2),
    .busy      (busy),
    .done      (done),
    .hit_cnt   (hit_cnt),
    .tot_sum   (tot_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       n;
    int       pl;
    int       win;
    int       gp;
    int       st;
    logic [3:0] d1;
    logic [3:0] d2;
    logic     sel;
    int       low_delay;
    int       low_len;
    int       exp_hit;
    int       exp_tot;
    int       exp_s0;
    int       exp_s1;
    int       exp_lat;
  } vec_t;

  typedef struct {
    int       hit;
    int       tot;
    int       s0;
    int       s1;
    logic [3:0] d1;
    logic [3:0] d2;
    int       lat;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int s0_cnt, s1_cnt, both_cnt, done_cnt, rise_num, rise_cyc;
  int due_at = -1;
  int low_left = 0;
  int resp_delay, resp_len;
  logic resp_sel;
  logic prev_strobe = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock cycle: sample outputs on the falling edge and play the
  // discriminator response to each strobe rise.
  task automatic tick();
    logic strobe;
    @(negedge clk);
    cyc++;
    if (S0 && S1) both_cnt++;
    if (S0) s0_cnt++;
    if (S1) s1_cnt++;
    if (done) done_cnt++;
    strobe = resp_sel ? S1 : S0;
    if (strobe && !prev_strobe) begin
      rise_num++;
      rise_cyc = cyc;
      if (resp_len > 0) due_at = cyc + resp_delay;
    end
    if (low_left > 0) begin
      low_left--;
      if (low_left == 0) outdis = 1'b1;
    end
    if (cyc == due_at) begin
      outdis   = 1'b0;
      low_left = resp_len;
    end
    prev_strobe = strobe;
  endtask

  task automatic clear_counts();
    s0_cnt = 0; s1_cnt = 0; both_cnt = 0; done_cnt = 0; rise_num = 0;
  endtask

  task automatic setup(input vec_t v);
    n_inj = CNT_W'(v.n); pulse_len = 8'(v.pl); window = 8'(v.win); gap = 8'(v.gp);
    settle = SETTLE_W'(v.st); dth1_cfg = v.d1; dth2_cfg = v.d2; inj_sel = v.sel;
    resp_sel = v.sel; resp_delay = v.low_delay; resp_len = v.low_len;
    clear_counts();
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    exp_t e;
    int start_cyc, lat, budget;
    v = vecs[idx];
    e.hit = v.exp_hit; e.tot = TOT_ON ? v.exp_tot : 0;
    e.s0 = v.exp_s0; e.s1 = v.exp_s1; e.d1 = v.d1; e.d2 = v.d2; e.lat = v.exp_lat;
    sbq.push_back(e);
    setup(v);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    checkOutput($sformatf("v%0d DTH1 after start", idx), 32'(DTH1), 32'(v.d1));
    checkOutput($sformatf("v%0d DTH2 after start", idx), 32'(DTH2), 32'(v.d2));
    checkOutput($sformatf("v%0d busy after start", idx), 32'(busy), 32'd1);
    budget = 0;
    while (done_cnt == 0 && budget < 4000) begin
      tick();
      budget++;
    end
    lat = cyc - start_cyc;
    if (done_cnt == 0) begin
      checkOutput($sformatf("v%0d done timeout", idx), 32'd0, 32'd1);
      return;
    end
    tick();
    checkOutput($sformatf("v%0d done one cycle", idx), 32'(done), 32'd0);
    checkOutput($sformatf("v%0d busy after done", idx), 32'(busy), 32'd0);
    repeat (3) tick();
    if (sbq.size() == 0) begin
      checkOutput($sformatf("v%0d scoreboard empty", idx), 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    checkOutput($sformatf("v%0d latency", idx), 32'(lat), 32'(e.lat));
    checkOutput($sformatf("v%0d hit_cnt", idx), 32'(hit_cnt), 32'(e.hit));
    checkOutput($sformatf("v%0d tot_sum", idx), 32'(tot_sum), 32'(e.tot));
    checkOutput($sformatf("v%0d S0 cycles", idx), 32'(s0_cnt), 32'(e.s0));
    checkOutput($sformatf("v%0d S1 cycles", idx), 32'(s1_cnt), 32'(e.s1));
    checkOutput($sformatf("v%0d both strobes", idx), 32'(both_cnt), 32'd0);
    checkOutput($sformatf("v%0d done pulses", idx), 32'(done_cnt), 32'd1);
    checkOutput($sformatf("v%0d DTH1 held", idx), 32'(DTH1), 32'(e.d1));
    checkOutput($sformatf("v%0d DTH2 held", idx), 32'(DTH2), 32'(e.d2));
  endtask

  task automatic wait_rise(input int target, input string name);
    int budget = 0;
    while (rise_num < target && budget < 500) begin
      tick();
      budget++;
    end
    if (rise_num < target) checkOutput(name, 32'(rise_num), 32'(target));
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " S0"}, 32'(S0), 32'd0);
    checkOutput({tag, " S1"}, 32'(S1), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " DTH1"}, 32'(DTH1), 32'd0);
    checkOutput({tag, " DTH2"}, 32'(DTH2), 32'd0);
    checkOutput({tag, " hit_cnt"}, 32'(hit_cnt), 32'd0);
    checkOutput({tag, " tot_sum"}, 32'(tot_sum), 32'd0);
  endtask

  // Main sequence: reset, table vectors, abort case, mid-burst reset.
  initial begin
    int r1;
    //            n  pl win gp st  d1     d2     sel dly len hit tot s0 s1 lat
    vecs[0] = '{4, 3, 5,  2, 10, 4'h5, 4'h3, 1'b0, 2, 2, 4, 8,  12, 0, 52};
    vecs[1] = '{4, 3, 5,  2, 10, 4'hA, 4'h6, 1'b0, 2, 0, 0, 0,  12, 0, 52};
    vecs[2] = '{3, 0, 0,  3, 0,  4'h1, 4'h2, 1'b1, 1, 0, 0, 0,  0,  3, 14};
    vecs[3] = '{3, 3, 12, 2, 1,  4'h7, 4'h8, 1'b0, 1, 6, 3, 18, 9,  0, 54};
    vecs[4] = '{2, 2, 4,  0, 3,  4'hC, 4'h9, 1'b1, 1, 3, 2, 6,  0,  4, 17};
    vecs[5] = '{0, 3, 5,  2, 7,  4'hE, 4'hF, 1'b0, 2, 2, 0, 0,  0,  0, 9};
    vecs[6] = '{0, 3, 5,  2, 0,  4'h2, 4'h4, 1'b1, 2, 2, 0, 0,  0,  0, 2};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; outdis = 1'b1;
    n_inj = '0; pulse_len = '0; window = '0; gap = '0; settle = '0;
    dth1_cfg = '0; dth2_cfg = '0; inj_sel = 1'b0;
    resp_sel = 1'b0; resp_delay = 0; resp_len = 0;
    clear_counts();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) applyStimulus(i);

    // Abort during the second injection, with a start ignored while busy.
    setup(vecs[0]);
    settle = 10'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rise(1, "abort first rise timeout");
    r1 = rise_cyc;
    tick();
    tick();
    start = 1'b1;
    dth1_cfg = 4'hF;
    tick();
    start = 1'b0;
    wait_rise(2, "abort second rise timeout");
    checkOutput("ignored start rise spacing", 32'(rise_cyc - r1), 32'd10);
    checkOutput("ignored start DTH1", 32'(DTH1), 32'h5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort S0", 32'(S0), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    repeat (20) tick();
    checkOutput("abort done pulses", 32'(done_cnt), 32'd0);
    checkOutput("abort hit_cnt", 32'(hit_cnt), 32'd1);

    // Reset asserted in the middle of an injection pulse.
    setup(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rise(1, "reset rise timeout");
    checkOutput("pre-reset S0", 32'(S0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    due_at = -1; low_left = 0; outdis = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (5) tick();
    checkOutput("post-reset done pulses", 32'(done_cnt), 32'd0);
    check_reset_values("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/lbnl_afe_cal_seq.md
LBNL_AFE_CAL_SEQ -- requirements
Module: lbnl_afe_cal_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the injection count and the hit count.
REQ-002 SHALL have parameter SETTLE_W, default 10: width of the trim-settle counter.
REQ-003 SHALL have port clk  in  1: single clock for all logic.
REQ-004 SHALL have port rst_n  in  1: asynchronous active-low reset.
REQ-005 SHALL have port start  in  1: one-cycle request to begin a calibration burst.
REQ-006 SHALL have port abort  in  1: terminates the burst immediately.
REQ-007 SHALL have port n_inj  in  CNT_W: number of injections per burst.
REQ-008 SHALL have ports pulse_len, window, gap  in  8 each: injection width, post-pulse hit window and inter-injection gap, all in cycles.
REQ-009 SHALL have port settle  in  SETTLE_W: trim-settle wait in cycles.
REQ-010 SHALL have ports dth1_cfg, dth2_cfg  in  4 each: threshold trims to apply.
REQ-011 SHALL have port inj_sel  in  1: 0 selects S0 (CAL_HI path), 1 selects S1 (CAL_MI path).
REQ-012 SHALL have port outdis  in  1: AFE discriminator output, asynchronous, active-low.
REQ-013 SHALL have ports S0, S1  out  1 each: AFE injection strobes.
REQ-014 SHALL have ports DTH1, DTH2  out  4 each: AFE threshold trims.
REQ-015 SHALL have ports busy, done  out  1 each: busy is high outside IDLE; done is a one-cycle completion pulse.
REQ-016 SHALL have port hit_cnt  out  CNT_W: number of injections that produced a hit.
REQ-017 SHALL have port tot_sum  out  16: accumulated time-over-threshold in cycles.

Function
REQ-018 SHALL implement the states IDLE, TRIM, SETTLE, INJECT, WAIT, GAP and DONE.
REQ-019 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-020 SHALL, on an accepted start at cycle t, register DTH1/DTH2 from the cfg inputs, latch all other cfg inputs and clear hit_cnt/tot_sum at t+1 (TRIM), then remain in SETTLE for settle cycles (0 means no SETTLE cycle).
REQ-021 SHALL, when n_inj==0, go TRIM->SETTLE->DONE with no strobe asserted.
REQ-022 SHALL, in INJECT, assert only the selected strobe for max(pulse_len,1) cycles; both strobes SHALL never be high together.
REQ-023 SHALL follow INJECT with WAIT for window cycles, then GAP for gap cycles (0 means the state is skipped), then go to INJECT if injections remain, else to DONE.
REQ-024 SHALL use hit = inverted outdis after a two-flop synchronizer; hit detection is enabled only in INJECT and WAIT.
REQ-025 SHALL increment hit_cnt at most once per injection, on the first enabled cycle with hit high, saturating at all-ones.
REQ-026 SHALL pulse done for exactly one cycle in DONE, then return to IDLE.
REQ-027 SHALL hold DTH1/DTH2, hit_cnt and tot_sum stable after DONE until the next accepted start.
REQ-028 SHALL, on abort in any non-IDLE state, go to IDLE next cycle with strobes low and no done pulse; counts are kept.
REQ-029 SHALL give abort priority over all other transitions when it coincides with them.

Reset
REQ-030 SHALL, while rst_n is low, force state IDLE, S0=S1=0, DTH1=DTH2=4'h0, busy=done=0, hit_cnt=0, tot_sum=0 and the synchronizer flops to 1 (no hit).
REQ-031 SHALL drop strobes asynchronously if reset asserts mid-burst, without producing a done pulse.

Configuration
REQ-032 SHALL, with LBNL_AFE_TOT_EN defined, add to tot_sum one count per enabled cycle with hit high, saturating at 16'hFFFF.
REQ-033 SHALL, with LBNL_AFE_TOT_EN undefined, keep the tot_sum port with tot_sum tied to 0 and no ToT logic synthesised.

Structure
REQ-034 SHALL place the state enum and the 4-bit trim width constant in the shared package lbnl_afe_pkg.
REQ-035 SHALL implement the outdis synchronizer as sub-module lbnl_afe_sync2.

Verification
REQ-036 Bench SHALL check: n_inj=4, pulse_len=3, window=5, gap=2, settle=10, inj_sel=0, outdis low 2 cycles after each S0 rise -> S0 high 3 cycles x4, S1 never high, hit_cnt=4, one done pulse.
REQ-037 Bench SHALL check: the same stimulus with outdis held high -> hit_cnt=0 and done asserted; with dth1_cfg=4'hA, DTH1=4'hA from the cycle after start.
REQ-038 Bench SHALL check: n_inj=0 -> no strobe, done appears settle+2 cycles after start, hit_cnt=0.
REQ-039 Bench SHALL check: abort during the second INJECT -> strobe low next cycle, busy=0, no done, hit_cnt=1; a second start during busy is ignored.
REQ-040 Bench SHALL check: outdis low for 6 cycles inside each of 3 windows, with LBNL_AFE_TOT_EN -> tot_sum=18, hit_cnt=3; without the macro -> tot_sum=0.
REQ-041 Bench SHALL check: rst_n pulsed low mid-INJECT -> S0/S1 go low immediately, all outputs return to their reset values.
